sn76489_bus_writer: RTL and testbench

//  CPU-side write port of the SN76489 PSG: accepts latch/data bytes on the 8-bit bus, decodes them
//  and holds the 8 control registers (4 attenuation, 3 tone frequency, 1 noise) that drive the tone,

---
 rtl/sn76489_pkg.sv | 30 +++
 rtl/sn76489_strobe_sync.sv | 33 +++
 rtl/sn76489_bus_writer.sv | 143 ++++++++++++++
 tb/tb_sn76489_bus_writer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sn76489_pkg.sv
// Shared types and constants for the SN76489 CPU write port.
package sn76489_pkg;

   // Register address latched from a latch byte: {channel[1:0], type}
   typedef enum logic [2:0] {
      FREQ0 = 3'd0,
      ATTN0 = 3'd1,
      FREQ1 = 3'd2,
      ATTN1 = 3'd3,
      FREQ2 = 3'd4,
      ATTN2 = 3'd5,
      NOISE = 3'd6,
      ATTN3 = 3'd7
   } psg_addr_e;

   // Bus byte fields
   localparam int unsigned LATCH_BIT = 7;
   localparam int unsigned ADDR_MSB  = 6;
   localparam int unsigned ADDR_LSB  = 4;

   localparam logic [3:0]  ATTN_SILENT = 4'hF;

   // Default register geometry
   localparam int unsigned NUM_TONES_DEFAULT    = 3;
   localparam int unsigned ATTN_BITS_DEFAULT    = 4;
   localparam int unsigned FREQ_BITS_DEFAULT    = 10;
   localparam int unsigned NOISE_BITS_DEFAULT   = 3;
   localparam int unsigned READY_CYCLES_DEFAULT = 32;

endpackage : sn76489_pkg

// File: rtl/sn76489_strobe_sync.sv
// Synchronizes the asynchronous active-low write strobe and flags its falling edge.
// The fall output is combinational from flops (one cycle wide per strobe).
module sn76489_strobe_sync (
   input  logic clk,
   input  logic reset,
   input  logic we_n_i,
   output logic fall_c_o
);

   logic s1_q, s2_q, s3_q;
   logic live_q, armed_q;

   // Two-flop synchronizer, edge-history flop, and arming after a genuine high sample.
   // Arming stops a strobe already low across reset release from looking like a fall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         s3_q    <= 1'b1;
         live_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         s1_q    <= we_n_i;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         live_q  <= 1'b1;
         armed_q <= armed_q | (live_q & s1_q);
      end
   end

   assign fall_c_o = s3_q & ~s2_q & armed_q;

endmodule : sn76489_strobe_sync

// File: rtl/sn76489_bus_writer.sv
// SN76489 CPU-side write port: byte decode, control register file, noise restart
// pulse and READY handshake. Define SN76489_READY_WAIT_EN to enable the READY
// busy window and overrun detection; otherwise every strobe is accepted.
module sn76489_bus_writer
   import sn76489_pkg::*;
#(
   parameter int unsigned NUM_TONES                = NUM_TONES_DEFAULT,
   parameter int unsigned ATTENUATION_CONTROL_BITS = ATTN_BITS_DEFAULT,
   parameter int unsigned FREQUENCY_COUNTER_BITS   = FREQ_BITS_DEFAULT,
   parameter int unsigned NOISE_CONTROL_BITS       = NOISE_BITS_DEFAULT,
   parameter int unsigned READY_CYCLES             = READY_CYCLES_DEFAULT
) (
   input  logic                                              clk,
   input  logic                                              reset,
   input  logic [7:0]                                        data_in,
   input  logic                                              we_n,
   output logic                                              ready,
   output logic                                              overrun,
   output logic [(NUM_TONES+1)*ATTENUATION_CONTROL_BITS-1:0] attn_flat,
   output logic [NUM_TONES*FREQUENCY_COUNTER_BITS-1:0]       tone_freq_flat,
   output logic [NOISE_CONTROL_BITS-1:0]                     noise_ctrl,
   output logic                                              noise_reset
);

   localparam int unsigned AW = ATTENUATION_CONTROL_BITS;
   localparam int unsigned FW = FREQUENCY_COUNTER_BITS;
   localparam int unsigned NW = NOISE_CONTROL_BITS;

   // The byte protocol only addresses this exact geometry
   if (NUM_TONES != 3 || AW != 4 || FW != 10 || NW != 3 || READY_CYCLES < 1) begin : g_param_check
      $error("sn76489_bus_writer: unsupported parameter set");
   end

   logic                        fall_c;
   logic                        accept_c;
   logic [7:0]                  data_q;
   psg_addr_e                   addr_q, addr_d;
   logic [NUM_TONES:0][AW-1:0]  attn_q, attn_d;
   logic [NUM_TONES-1:0][FW-1:0] freq_q, freq_d;
   logic [NW-1:0]               noise_q, noise_d;
   logic                        nres_q, nres_d;
   logic [2:0]                  tgt;
   logic [1:0]                  ch;
   logic                        ready_q;

   sn76489_strobe_sync u_sync (
      .clk      (clk),
      .reset    (reset),
      .we_n_i   (we_n),
      .fall_c_o (fall_c)
   );

   assign accept_c = fall_c & ready_q;

   // Decode the accepted byte against the latched (or newly latched) address
   always_comb begin
      addr_d  = addr_q;
      attn_d  = attn_q;
      freq_d  = freq_q;
      noise_d = noise_q;
      nres_d  = 1'b0;
      tgt     = data_q[LATCH_BIT] ? data_q[ADDR_MSB:ADDR_LSB] : 3'(addr_q);
      ch      = tgt[2:1];
      if (accept_c) begin
         if (data_q[LATCH_BIT]) begin
            addr_d = psg_addr_e'(tgt);
         end
         if (tgt[0]) begin
            attn_d[ch] = AW'(data_q[3:0]);
         end else if (tgt == 3'(NOISE)) begin
            noise_d = NW'(data_q[2:0]);
            nres_d  = 1'b1;
         end else if (data_q[LATCH_BIT]) begin
            freq_d[ch][3:0] = data_q[3:0];
         end else begin
            freq_d[ch][FW-1:4] = (FW-4)'(data_q[5:0]);
         end
      end
   end

   // Bus data capture and register file update
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q  <= 8'h00;
         addr_q  <= FREQ0;
         for (int i = 0; i <= NUM_TONES; i++) begin
            attn_q[i] <= AW'(ATTN_SILENT);
         end
         freq_q  <= '0;
         noise_q <= '0;
         nres_q  <= 1'b0;
      end else begin
         data_q  <= data_in;
         addr_q  <= addr_d;
         attn_q  <= attn_d;
         freq_q  <= freq_d;
         noise_q <= noise_d;
         nres_q  <= nres_d;
      end
   end

`ifdef SN76489_READY_WAIT_EN
   localparam int unsigned CW = (READY_CYCLES > 1) ? $clog2(READY_CYCLES) : 1;

   logic [CW-1:0] cnt_q;
   logic          ovr_q;

   // Busy window: READY low for exactly READY_CYCLES cycles after each accept
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready_q <= 1'b1;
         ovr_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         if (fall_c && !ready_q) begin
            ovr_q <= 1'b1;
         end
         if (accept_c) begin
            ready_q <= 1'b0;
            cnt_q   <= CW'(READY_CYCLES - 1);
         end else if (!ready_q) begin
            if (cnt_q == '0) begin
               ready_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
         end
      end
   end

   assign overrun = ovr_q;
`else
   assign ready_q = 1'b1;
   assign overrun = 1'b0;
`endif

   assign ready          = ready_q;
   assign attn_flat      = attn_q;
   assign tone_freq_flat = freq_q;
   assign noise_ctrl     = noise_q;
   assign noise_reset    = nres_q;

endmodule : sn76489_bus_writer

// File: tb/tb_sn76489_bus_writer.sv
// Scoreboard bench for sn76489_bus_writer: driver pushes expected snapshots
// computed by a byte-level reference model; a monitor compares them in time.
module tb_sn76489_bus_writer;

   localparam int READY_N = 32;

   logic        clk, reset, we_n, ready, overrun, noise_reset;
   logic [7:0]  data_in;
   logic [15:0] attn_flat;
   logic [29:0] tone_freq_flat;
   logic [2:0]  noise_ctrl;

   sn76489_bus_writer dut (
      .clk            (clk),
      .reset          (reset),
      .data_in        (data_in),
      .we_n           (we_n),
      .ready          (ready),
      .overrun        (overrun),
      .attn_flat      (attn_flat),
      .tone_freq_flat (tone_freq_flat),
      .noise_ctrl     (noise_ctrl),
      .noise_reset    (noise_reset)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      int          id;
      logic [15:0] attn;
      logic [29:0] freq;
      logic [2:0]  noise;
      logic        nres;
      logic        rdy;
      logic        ovr;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0;
   int   n_pass  = 0;
   int   next_id = 0;

   // Reference model state
   int m_attn[4];
   int m_freq[3];
   int m_noise, m_addr, m_last_a, m_ready_from;
   bit m_ovr;

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) m_attn[i] = 15;
      for (int i = 0; i < 3; i++) m_freq[i] = 0;
      m_noise      = 0;
      m_addr       = 0;
      m_last_a     = -100000;
      m_ready_from = -100000;
      m_ovr        = 1'b0;
   endfunction

   function automatic bit exp_ready(input int c);
`ifdef SN76489_READY_WAIT_EN
      return (c >= m_last_a + READY_N);
`else
      return (c >= 0) || (c < 0);
`endif
   endfunction

   // Apply one bus byte whose accept edge is a_cyc; returns whether a noise pulse results
   function automatic bit model_write(input logic [7:0] b, input int a_cyc);
      int v, ch;
      bit acc;
      v = int'(b);
`ifdef SN76489_READY_WAIT_EN
      acc = (a_cyc >= m_ready_from);
`else
      acc = 1'b1;
`endif
      if (!acc) begin
         m_ovr = 1'b1;
         return 1'b0;
      end
      m_last_a     = a_cyc;
      m_ready_from = a_cyc + READY_N + 1;
      if (v >= 128) m_addr = (v / 16) % 8;
      ch = m_addr / 2;
      if (m_addr % 2 == 1) begin
         m_attn[ch] = v % 16;
      end else if (ch == 3) begin
         m_noise = v % 8;
         return 1'b1;
      end else if (v >= 128) begin
         m_freq[ch] = (m_freq[ch] / 16) * 16 + v % 16;
      end else begin
         m_freq[ch] = m_freq[ch] % 16 + (v % 64) * 16;
      end
      return 1'b0;
   endfunction

   function automatic exp_t mk_exp(input int c, input bit nres);
      exp_t e;
      e.cyc   = c;
      e.id    = next_id;
      e.attn  = {4'(m_attn[3]), 4'(m_attn[2]), 4'(m_attn[1]), 4'(m_attn[0])};
      e.freq  = {10'(m_freq[2]), 10'(m_freq[1]), 10'(m_freq[0])};
      e.noise = 3'(m_noise);
      e.nres  = nres;
      e.rdy   = exp_ready(c);
      e.ovr   = m_ovr;
      next_id++;
      return e;
   endfunction

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s (entry %0d, cycle %0d): got %0h expected %0h", nm, id, cyc, act, exp);
   endtask

   // Monitor: compare outputs when an expected snapshot falls due
   initial begin
      exp_t e;
      bit   pend;
      int   pend_id;
      pend = 1'b0;
      pend_id = 0;
      forever begin
         @(negedge clk);
         if (pend) begin
            chk("noise_reset_width", pend_id, 32'(noise_reset), 32'd0);
            pend = 1'b0;
         end
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
               n_total++;
               $display("FAIL missed_check (entry %0d): due cycle %0d, now %0d", e.id, e.cyc, cyc);
            end else begin
               chk("attn_flat",      e.id, 32'(attn_flat),      32'(e.attn));
               chk("tone_freq_flat", e.id, 32'(tone_freq_flat), 32'(e.freq));
               chk("noise_ctrl",     e.id, 32'(noise_ctrl),     32'(e.noise));
               chk("noise_reset",    e.id, 32'(noise_reset),    32'(e.nres));
               chk("ready",          e.id, 32'(ready),          32'(e.rdy));
               chk("overrun",        e.id, 32'(overrun),        32'(e.ovr));
               if (e.nres) begin
                  pend    = 1'b1;
                  pend_id = e.id;
               end
            end
         end
      end
   end

   task automatic wait_ready();
      while (cyc + 4 < m_ready_from) @(negedge clk);
   endtask

   // One strobe: low across low_n clock edges; data scrambled after release
   task automatic do_write(input logic [7:0] b, input int low_n, output int e1);
      bit p;
      @(negedge clk);
      we_n    = 1'b0;
      data_in = b;
      e1      = cyc + 1;
      p       = model_write(b, e1 + 2);
      sb.push_back(mk_exp(e1 + 2, p));
      repeat (low_n) @(negedge clk);
      we_n    = 1'b1;
      data_in = 8'($urandom);
   endtask

   task automatic write_byte(input logic [7:0] b);
      int e1;
      wait_ready();
      do_write(b, 2, e1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int          e1, e1b;
      logic [7:0]  b;
      reset   = 1'b1;
      we_n    = 1'b1;
      data_in = 8'h00;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      sb.push_back(mk_exp(cyc + 2, 1'b0));
      repeat (4) @(negedge clk);

      // Frequency latch + data byte, attenuation reuse, noise writes
      write_byte(8'h8E);
      write_byte(8'h0F);
      write_byte(8'hD5);
      write_byte(8'h09);
      write_byte(8'hE6);
      write_byte(8'h03);

`ifdef SN76489_READY_WAIT_EN
      // Second strobe inside the busy window is dropped; READY timing at the edge
      wait_ready();
      do_write(8'h84, 2, e1);
      while (cyc < e1 + 8) @(negedge clk);
      do_write(8'h9C, 3, e1b);
      sb.push_back(mk_exp(e1 + 2 + READY_N - 1, 1'b0));
      sb.push_back(mk_exp(e1 + 2 + READY_N, 1'b0));
      wait_ready();
      repeat (2) @(negedge clk);
`endif

      // Randomized byte stream with varying strobe widths and gaps
      for (int i = 0; i < 80; i++) begin
         b = 8'($urandom);
`ifdef SN76489_READY_WAIT_EN
         if ($urandom_range(0, 3) != 0) wait_ready();
`endif
         do_write(b, int'($urandom_range(2, 4)), e1);
         repeat ($urandom_range(2, 5)) @(negedge clk);
      end

      // Reset mid-strobe (READY low when waiting is enabled), release with strobe still low
      wait_ready();
      @(negedge clk);
      we_n    = 1'b0;
      data_in = 8'h9A;
      e1      = cyc + 1;
      sb.push_back(mk_exp(e1 + 2, model_write(8'h9A, e1 + 2)));
      repeat (4) @(negedge clk);
      reset = 1'b1;
      model_reset();
      sb.push_back(mk_exp(cyc + 2, 1'b0));
      repeat (3) @(negedge clk);
      reset = 1'b0;
      sb.push_back(mk_exp(cyc + 3, 1'b0));
      sb.push_back(mk_exp(cyc + 6, 1'b0));
      repeat (7) @(negedge clk);
      we_n = 1'b1;
      repeat (4) @(negedge clk);
      write_byte(8'h9A);
      write_byte(8'h3F);

      // Drain the scoreboard with a bounded wait
      for (int t = 0; t < 500 && sb.size() > 0; t++) @(negedge clk);
      if (sb.size() > 0) begin
         n_total++;
         $display("FAIL drain_timeout: %0d entries left, expected 0", sb.size());
      end
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_sn76489_bus_writer
